// File: rtl/nn_fetch_pkg.sv
// Shared constants, FSM state encoding and layer type for the parameter-image fetch controller.
package nn_fetch_pkg;
  localparam int NUM_HIDDEN   = 8;
  localparam int HIDDEN_WORDS = 36;
  localparam int NUM_OUTPUT   = 10;
  localparam int OUTPUT_WORDS = 2;
  localparam int TOTAL_WORDS  = NUM_HIDDEN * (HIDDEN_WORDS + 1) + NUM_OUTPUT * (OUTPUT_WORDS + 1);
  localparam int ADDR_W       = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    LAYER_HIDDEN = 1'b0,
    LAYER_OUTPUT = 1'b1
  } layer_t;
endpackage

// File: rtl/nn_fetch_index_cnt.sv
// Word / neuron / layer position of the fetch pointer within the parameter image.
module nn_fetch_index_cnt
  import nn_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       advance,
  output logic       is_bias,
  output logic       last_word,
  output logic [3:0] neuron_idx,
  output layer_t     layer,
  output logic       last_of_image
);
  logic [5:0] word_idx;
  logic [5:0] words_n;

  assign words_n       = (layer == LAYER_OUTPUT) ? 6'(OUTPUT_WORDS) : 6'(HIDDEN_WORDS);
  assign is_bias       = (word_idx == 6'd0);
  assign last_word     = (word_idx == words_n);
  assign last_of_image = (layer == LAYER_OUTPUT) && (neuron_idx == 4'(NUM_OUTPUT - 1)) && last_word;

  // The pointer parks on the final word; only a clear moves it back to the start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_idx   <= '0;
      neuron_idx <= '0;
      layer      <= LAYER_HIDDEN;
    end else if (clear) begin
      word_idx   <= '0;
      neuron_idx <= '0;
      layer      <= LAYER_HIDDEN;
    end else if (advance && !last_of_image) begin
      if (last_word) begin
        word_idx <= '0;
        if (layer == LAYER_HIDDEN && neuron_idx == 4'(NUM_HIDDEN - 1)) begin
          layer      <= LAYER_OUTPUT;
          neuron_idx <= '0;
        end else begin
          neuron_idx <= neuron_idx + 4'd1;
        end
      end else begin
        word_idx <= word_idx + 6'd1;
      end
    end
  end
endmodule

// File: rtl/nn_weight_fetch_ctrl.sv
// Walks the flash parameter image and hands each tagged word to the MAC datapath.
// Optional macro NN_FETCH_PREFETCH_EN adds a one-entry prefetch register for back-to-back words.
module nn_weight_fetch_ctrl
  import nn_fetch_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int FM_WAIT   = 1,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic [ADDR_W-1:0] fm_address,
  input  logic [DATA_W-1:0] fm_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              is_bias,
  output logic              layer,
  output logic [3:0]        neuron_idx,
  output logic              last_word,
  output logic              busy,
  output logic              done
);
  localparam logic [7:0]        WAIT_LAST = 8'(FM_WAIT - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t     state, next_state;
  logic [7:0] wait_cnt;
  logic       xfer, fetching, fetch_done, advance, ld_fetch;
  logic       out_last;
  layer_t     layer_q;

  logic       c_is_bias, c_last_word, c_last_of_image;
  logic [3:0] c_neuron_idx;
  layer_t     c_layer;

`ifdef NN_FETCH_PREFETCH_EN
  logic              pf_valid, fetch_end, ld_pf, ld_from_pf;
  logic [DATA_W-1:0] pf_data;
  logic              pf_is_bias, pf_last_word, pf_last;
  logic [3:0]        pf_neuron_idx;
  layer_t            pf_layer;
`endif

  assign xfer  = out_valid && out_ready;
  assign layer = layer_q;

  nn_fetch_index_cnt u_index_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state == DONE),
    .advance      (advance),
    .is_bias      (c_is_bias),
    .last_word    (c_last_word),
    .neuron_idx   (c_neuron_idx),
    .layer        (c_layer),
    .last_of_image(c_last_of_image)
  );

  // With prefetch, the fetch pointer runs one word ahead of the presented word.
  always_comb begin
`ifdef NN_FETCH_PREFETCH_EN
    fetching   = (state == ADDR || state == PRESENT) && !pf_valid && !fetch_end;
    fetch_done = fetching && (wait_cnt == WAIT_LAST);
    advance    = fetch_done;
    ld_fetch   = fetch_done && (state == ADDR || xfer);
    ld_pf      = fetch_done && (state == PRESENT) && !xfer;
    ld_from_pf = (state == PRESENT) && xfer && pf_valid && !out_last;
`else
    fetching   = (state == ADDR);
    fetch_done = fetching && (wait_cnt == WAIT_LAST);
    advance    = (state == PRESENT) && xfer && !out_last;
    ld_fetch   = fetch_done;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ADDR;
      ADDR:    if (fetch_done) next_state = PRESENT;
      PRESENT: begin
        if (xfer) begin
          if (out_last) next_state = DONE;
`ifdef NN_FETCH_PREFETCH_EN
          else if (!pf_valid && !fetch_done) next_state = ADDR;
`else
          else next_state = ADDR;
`endif
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == PRESENT);
    busy      = (state == ADDR) || (state == PRESENT);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fm_address <= BASE;
      wait_cnt   <= '0;
      out_data   <= '0;
      is_bias    <= 1'b0;
      layer_q    <= LAYER_HIDDEN;
      neuron_idx <= '0;
      last_word  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        fm_address <= BASE;
        wait_cnt   <= '0;
      end else if (state == DONE) begin
        fm_address <= BASE;
      end else begin
        if (fetch_done)    wait_cnt <= '0;
        else if (fetching) wait_cnt <= wait_cnt + 8'd1;
        if (advance && !c_last_of_image) fm_address <= fm_address + ADDR_W'(1);
      end
      if (ld_fetch) begin
        out_data   <= fm_data;
        is_bias    <= c_is_bias;
        layer_q    <= c_layer;
        neuron_idx <= c_neuron_idx;
        last_word  <= c_last_word;
        out_last   <= c_last_of_image;
      end
`ifdef NN_FETCH_PREFETCH_EN
      else if (ld_from_pf) begin
        out_data   <= pf_data;
        is_bias    <= pf_is_bias;
        layer_q    <= pf_layer;
        neuron_idx <= pf_neuron_idx;
        last_word  <= pf_last_word;
        out_last   <= pf_last;
      end
`endif
    end
  end

`ifdef NN_FETCH_PREFETCH_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pf_valid  <= 1'b0;
      fetch_end <= 1'b0;
    end else if (state == IDLE && start) begin
      pf_valid  <= 1'b0;
      fetch_end <= 1'b0;
    end else begin
      if (advance && c_last_of_image) fetch_end <= 1'b1;
      if (ld_pf)           pf_valid <= 1'b1;
      else if (ld_from_pf) pf_valid <= 1'b0;
    end
  end

  // Prefetch payload is qualified by pf_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (ld_pf) begin
      pf_data       <= fm_data;
      pf_is_bias    <= c_is_bias;
      pf_layer      <= c_layer;
      pf_neuron_idx <= c_neuron_idx;
      pf_last_word  <= c_last_word;
      pf_last       <= c_last_of_image;
    end
  end
`endif
endmodule

// File: doc/nn_weight_fetch_ctrl.md
Name: nn_weight_fetch_ctrl

Overview:
Sequences the external flash model that holds the network parameters. It walks the whole parameter image in order: hidden-layer neurons first, then output-layer neurons. Each parameter word is delivered to the MAC datapath over a valid/ready handshake, tagged with bias/weight, layer, neuron index and last-word flags. One start pulse fetches the full image, 326 words.

Parameters:
NUM_HIDDEN, 8, hidden neurons
HIDDEN_WORDS, 36, packed weight words per hidden neuron (4x4-bit weights per word)
NUM_OUTPUT, 10, output neurons
OUTPUT_WORDS, 2, packed weight words per output neuron
BASE_ADDR, 0, flash address of the first hidden bias
FM_WAIT, 1, cycles the address is held before fm_data is sampled (>=1)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to fetch the full image
fm_address  out  16  registered flash address
fm_data  in  16  flash read data (combinational from fm_address)
out_data  out  16  current parameter word
out_valid  out  1  out_data and its tags are valid
out_ready  in  1  datapath accepts the word
is_bias  out  1  word is a neuron bias (signed 16-bit)
layer  out  1  0 = hidden, 1 = output
neuron_idx  out  4  neuron index within the layer
last_word  out  1  final weight word of the current neuron
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset: all outputs 0, fm_address = BASE_ADDR, state IDLE, all counters 0. Reset mid-run aborts immediately with no completion pulse.
- Image layout: per neuron, one bias word, then N weight words (N = HIDDEN_WORDS or OUTPUT_WORDS). Words are contiguous.
  - Hidden neurons occupy BASE_ADDR+0..295.
  - Output neurons occupy BASE_ADDR+296..325.
- States:
  - IDLE: start=1 -> ADDR with busy=1 and fm_address=BASE_ADDR. start is ignored in every other state.
  - ADDR: hold fm_address for FM_WAIT cycles. At the end of the last cycle, register fm_data into out_data, load the tags, then go to PRESENT.
  - PRESENT: out_valid=1. out_data and the tags are stable while out_ready=0.
    - On out_valid & out_ready, if the transfer was address BASE_ADDR+325 -> DONE.
    - Otherwise fm_address+1, update counters, out_valid=0 next cycle, go to ADDR.
  - DONE: done=1 for one cycle, busy=0, out_valid=0, fm_address returns to BASE_ADDR, then IDLE.
- Counters: word_idx runs 0..N (0 = bias).
  - last_word = (word_idx==N).
  - On last_word, neuron_idx increments. On the last neuron of the hidden layer, layer goes to 1 and neuron_idx goes to 0.
- Data passes through unmodified; no sign handling in this block.
- Throughput without prefetch is one word per FM_WAIT+1 cycles with out_ready held high.

Optional Feature:
NN_FETCH_PREFETCH_EN
- Defined: adds a one-entry prefetch register. During PRESENT the next address is driven and fetched after FM_WAIT cycles. On handshake with the prefetch valid, the next word is presented the following cycle with no ADDR bubble. Sustained rate is one word per FM_WAIT cycles; FM_WAIT=1 gives one word per cycle. Ordering, tags and done timing relative to the last transfer are unchanged.
- Undefined: the baseline behaviour above.

Decomposition:
- Package nn_fetch_pkg holds:
  - the constants NUM_HIDDEN, HIDDEN_WORDS, NUM_OUTPUT, OUTPUT_WORDS and TOTAL_WORDS=326;
  - the state enum (IDLE, ADDR, PRESENT, DONE);
  - typedef layer_t.
- One sub-module, nn_fetch_index_cnt, holds the word/neuron/layer counters. It produces is_bias, last_word, neuron_idx, layer and last_of_image on an advance strobe.

Test Plan:
- Reset asserted mid-idle -> all outputs 0 and fm_address=0; start held low -> no activity.
- Full run, out_ready=1, FM_WAIT=1, prefetch off -> 326 transfers at addresses 0..325 in order.
  - is_bias=1 exactly at 0,37,74,...,259,296,299,...,323.
  - One done pulse, 652 cycles from start to done.
- Backpressure: out_ready=0 for 5 cycles on address 3 -> out_valid, out_data and fm_address=3 all stable; the word is transferred once.
- Layer boundary -> address 295 transfers with layer=0, neuron_idx=7, last_word=1. Address 296 follows with is_bias=1, layer=1, neuron_idx=0.
- Reset at the 100th transfer, then a new start -> no done pulse from the aborted run; restarts at address 0. start pulses while busy are ignored, with no duplicate words.
- NN_FETCH_PREFETCH_EN with FM_WAIT=1 and out_ready=1 -> consecutive transfers on back-to-back cycles; the same 326-word sequence and tags as the baseline.
